// File: rtl/regfile_dump_reader.sv
// Debug dump engine: walks an inclusive register range through the register
// file's async read port and streams each word out LSB byte first on valid/ready.
module regfile_dump_reader #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_SEL_BITS   = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [REG_SEL_BITS-1:0]   first_sel,
    input  logic [REG_SEL_BITS-1:0]   last_sel,
    output logic [REG_SEL_BITS-1:0]   read_sel,
    input  logic [REG_DATA_WIDTH-1:0] read_data,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      tx_last,
    output logic                      busy,
    output logic                      done,
    output logic                      range_err
);

    localparam int BYTES  = REG_DATA_WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BIDX_W-1:0]       LAST_IDX = BIDX_W'(BYTES - 1);
    localparam logic [BIDX_W-1:0]       BIDX_ONE = BIDX_W'(1);
    localparam logic [REG_SEL_BITS-1:0] SEL_ONE  = REG_SEL_BITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [REG_SEL_BITS-1:0]   cur_sel;
    logic [REG_SEL_BITS-1:0]   end_sel;
    logic [REG_DATA_WIDTH-1:0] word_q;
    logic [BIDX_W-1:0]         byte_idx;
    logic                      err_q;

    logic latch_range;
    logic load_word;
    logic shift_word;
    logic advance_sel;
    logic bad_range;
    logic last_byte;
    logic last_reg;

    assign last_byte = (byte_idx == LAST_IDX);
    assign last_reg  = (cur_sel == end_sel);

    // Handshake: a byte moves on a cycle where tx_valid && tx_ready; while
    // stalled, tx_data/tx_last hold and tx_valid only drops for abort or reset.
    always_comb begin
        state_next  = state;
        latch_range = 1'b0;
        load_word   = 1'b0;
        shift_word  = 1'b0;
        advance_sel = 1'b0;
        bad_range   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (first_sel <= last_sel) begin
                        latch_range = 1'b1;
                        state_next  = READ;
                    end else begin
                        bad_range = 1'b1;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    load_word  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (tx_ready) begin
                    if (!last_byte) begin
                        shift_word = 1'b1;
                    end else if (last_reg) begin
                        state_next = DONE;
                    end else begin
                        advance_sel = 1'b1;
                        state_next  = READ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cur_sel  <= '0;
            end_sel  <= '0;
            word_q   <= '0;
            byte_idx <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= bad_range;
            if (latch_range) begin
                cur_sel <= first_sel;
                end_sel <= last_sel;
            end
            if (load_word) begin
                word_q   <= read_data;
                byte_idx <= '0;
            end
            if (shift_word) begin
                word_q   <= word_q >> 8;
                byte_idx <= byte_idx + BIDX_ONE;
            end
            // Termination is on equality, so cur_sel never increments past end_sel.
            if (advance_sel) begin
                cur_sel <= cur_sel + SEL_ONE;
            end
        end
    end

    assign read_sel  = cur_sel;
    assign tx_data   = word_q[7:0];
    assign tx_valid  = (state == SEND);
    assign tx_last   = (state == SEND) && last_byte && last_reg;
    assign busy      = (state == READ) || (state == SEND);
    assign done      = (state == DONE) || err_q;
    assign range_err = err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: queue-based reference model checked every
// cycle, plus directed dumps with literal byte/latency expectations.
module tb_regfile_dump_reader;
    localparam int DW    = 32;
    localparam int SB    = 5;
    localparam int BYTES = DW / 8;
    localparam int NREG  = 1 << SB;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tx_ready = 1'b1;
    logic [SB-1:0] first_sel = '0;
    logic [SB-1:0] last_sel = '0;
    logic [SB-1:0] read_sel;
    logic [DW-1:0] read_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          busy;
    logic          done;
    logic          range_err;

    logic [DW-1:0] regs [NREG];
    assign read_data = regs[read_sel];

    regfile_dump_reader #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SB)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .first_sel(first_sel), .last_sel(last_sel), .read_sel(read_sel),
        .read_data(read_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .done(done),
        .range_err(range_err)
    );

    // ---------------- clock / reset block ----------------
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int ready_mode = 0;
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    function automatic void chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Model: todo_q holds registers still to dump (head = current one),
    // exp_q holds the bytes of the current word not yet handed over.
    int            todo_q[$];
    logic [7:0]    exp_q[$];
    bit            rd_cycle = 0;
    bit            finishing = 0;
    bit            err_due = 0;
    logic [SB-1:0] m_sel = '0;

    logic [7:0] got_q[$];
    bit         got_last[$];
    logic [7:0] ref_q[$];
    int start_at = -1, done_at = -1, err_at = -1, last_hs_at = -1, done_cnt = 0;

    always @(negedge clock) begin
        bit m_idle;
        bit nxt_done;
        bit nxt_err;
        if (chk_en) begin
            chk("read_sel", DW'(read_sel), DW'(m_sel));
            chk("tx_valid", DW'(tx_valid), DW'(exp_q.size() > 0));
            chk("busy", DW'(busy), DW'(rd_cycle || exp_q.size() > 0));
            chk("done", DW'(done), DW'(finishing || err_due));
            chk("range_err", DW'(range_err), DW'(err_due));
            if (exp_q.size() > 0) begin
                chk("tx_data", DW'(tx_data), DW'(exp_q[0]));
                chk("tx_last", DW'(tx_last), DW'(exp_q.size() == 1 && todo_q.size() == 1));
            end else begin
                chk("tx_last_idle", DW'(tx_last), DW'(0));
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                got_last.push_back(tx_last);
                if (tx_last) last_hs_at = cyc;
            end
            if (done) begin
                done_at = cyc;
                done_cnt++;
                if (range_err) err_at = cyc;
            end
        end
        m_idle   = !rd_cycle && exp_q.size() == 0 && !finishing;
        nxt_done = 1'b0;
        nxt_err  = 1'b0;
        if (!reset) begin
            todo_q.delete();
            exp_q.delete();
            rd_cycle = 1'b0;
            m_sel    = '0;
        end else if (rd_cycle) begin
            rd_cycle = 1'b0;
            if (abort) todo_q.delete();
            else for (int b = 0; b < BYTES; b++) exp_q.push_back(regs[m_sel][8*b +: 8]);
        end else if (exp_q.size() > 0) begin
            if (abort) begin
                exp_q.delete();
                todo_q.delete();
            end else if (tx_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    void'(todo_q.pop_front());
                    if (todo_q.size() == 0) nxt_done = 1'b1;
                    else begin
                        rd_cycle = 1'b1;
                        m_sel    = SB'(todo_q[0]);
                    end
                end
            end
        end else if (m_idle && start) begin
            start_at = cyc;
            if (first_sel <= last_sel) begin
                for (int r = int'(first_sel); r <= int'(last_sel); r++) todo_q.push_back(r);
                m_sel    = first_sel;
                rd_cycle = 1'b1;
            end else begin
                nxt_err = 1'b1;
            end
        end
        finishing = nxt_done;
        err_due   = nxt_err;
    end

    // ---------------- driver tasks ----------------
    task automatic step(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_start(int f, int l);
        first_sel = SB'(f);
        last_sel  = SB'(l);
        start     = 1'b1;
        step(1);
        start = 1'b0;
        got_q.delete();
        got_last.delete();
    endtask

    task automatic wait_done(int max);
        int n = 0;
        while (!done && n < max) begin
            step(1);
            n++;
        end
        if (!done) chk("done_timeout", DW'(done), DW'(1));
        step(1);
    endtask

    task automatic push_word(logic [DW-1:0] w);
        for (int b = 0; b < BYTES; b++) ref_q.push_back(w[8*b +: 8]);
    endtask

    task automatic check_stream(string tag);
        chk({tag, "_count"}, DW'(got_q.size()), DW'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_byte"}, DW'(got_q[i]), DW'(ref_q[i]));
            chk({tag, "_last"}, DW'(got_last[i]), DW'(i == ref_q.size() - 1));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dc;
        int f;
        int l;
        int n;
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        regs[0] = '0;
        @(posedge clock);
        #1;
        chk_en = 1;
        step(1);
        chk("rst_tx_data", DW'(tx_data), DW'(0));
        chk("rst_read_sel", DW'(read_sel), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_tx_valid", DW'(tx_valid), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        reset = 1'b1;
        step(1);

        // Two-register dump, sink always ready
        regs[1] = 32'h11223344;
        regs[2] = 32'hA5A55A5A;
        ready_mode = 0;
        do_start(1, 2);
        wait_done(100);
        ref_q = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h5A, 8'h5A, 8'hA5, 8'hA5};
        check_stream("dump12");
        chk("dump12_done_lat", DW'(done_at - start_at), DW'(11));
        chk("dump12_busy_after", DW'(busy), DW'(0));

        // Same dump with alternating back-pressure
        ready_mode = 1;
        do_start(1, 2);
        wait_done(200);
        check_stream("stall12");
        chk("stall12_done_after_hs", DW'(done_at - last_hs_at), DW'(1));

        // Top register alone: no wrap of the select
        ready_mode = 0;
        regs[31] = 32'hDEADBEEF;
        do_start(31, 31);
        wait_done(100);
        ref_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        check_stream("top31");
        chk("top31_done_lat", DW'(done_at - start_at), DW'(6));
        chk("top31_sel", DW'(read_sel), DW'(31));

        // Illegal range
        err_at = -1;
        do_start(5, 3);
        step(3);
        chk("err_lat", DW'(err_at - start_at), DW'(1));
        chk("err_no_bytes", DW'(got_q.size()), DW'(0));

        // Reset in SEND, byte 2 of register 1, then a clean dump of x0
        do_start(1, 2);
        step(3);
        dc = done_cnt;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("rst_mid_valid", DW'(tx_valid), DW'(0));
        chk("rst_mid_busy", DW'(busy), DW'(0));
        step(12);
        chk("rst_mid_no_done", DW'(done_cnt), DW'(dc));
        do_start(0, 0);
        wait_done(100);
        ref_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        check_stream("x0");

        // Ignored restart, then abort in SEND
        dc = done_cnt;
        do_start(0, 5);
        first_sel = SB'(7);
        last_sel  = SB'(9);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_valid", DW'(tx_valid), DW'(0));
        chk("abort_busy", DW'(busy), DW'(0));
        step(30);
        chk("abort_no_done", DW'(done_cnt), DW'(dc));
        regs[3] = 32'h01020304;
        do_start(3, 3);
        wait_done(100);
        ref_q = '{8'h04, 8'h03, 8'h02, 8'h01};
        check_stream("x3");

        // Snapshot: rewrite x2 after its read, x3 before its read
        regs[2] = 32'hCAFEF00D;
        regs[3] = 32'h0BADC0DE;
        do_start(2, 3);
        step(1);
        regs[2] = 32'h12345678;
        regs[3] = 32'h9ABCDEF0;
        wait_done(100);
        ref_q.delete();
        push_word(32'hCAFEF00D);
        push_word(32'h9ABCDEF0);
        check_stream("snap");

        // Randomized dumps with writes, back-pressure, stray starts and aborts
        for (int it = 0; it < 40; it++) begin
            ready_mode = $urandom_range(0, 2);
            f = $urandom_range(0, NREG - 1);
            l = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NREG - 1))
                                            : ((f + int'($urandom_range(0, 8)) > NREG - 1) ? NREG - 1
                                                                                            : f + int'($urandom_range(0, 8)));
            do_start(f, l);
            n = 0;
            while ((busy || done) && n < 600) begin
                if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NREG - 1)] = $urandom;
                abort = ($urandom_range(0, 63) == 0);
                start = busy && ($urandom_range(0, 15) == 0);
                step(1);
                n++;
            end
            start = 1'b0;
            abort = 1'b0;
            if (n >= 600) chk("rand_timeout", DW'(busy), DW'(0));
            step(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
